// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Processor-side initiator for a single-port word data memory.
//            It accepts byte, halfword and word loads and stores at byte
//            addresses. Sub-word stores use read-modify-write. Load data is
//            sign- or zero-extended. Out-of-range and illegal-size requests
//            are rejected.
// Options  : LSU_MISALIGN_TRAP_EN - when defined, misaligned half/word
//            accesses are rejected. When undefined, the low offset bits are
//            truncated instead.
// Ports    : CLK, RST_N (async active-low)
//            REQ/RW/SIZE/SIGNED/ADDR/WDATA  request from execute stage
//            READY/DONE/ERR/RDATA           handshake and load result
//            MEM_WE/MEM_ADDRESS/MEM_DATA    to memory; MEM_Q from memory
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int ADDR_W = 10
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        REQ,
    input  logic        RW,
    input  logic [1:0]  SIZE,
    input  logic        SIGNED,
    input  logic [31:0] ADDR,
    input  logic [31:0] WDATA,
    output logic        READY,
    output logic        DONE,
    output logic        ERR,
    output logic [31:0] RDATA,
    output logic        MEM_WE,
    output logic [31:0] MEM_ADDRESS,
    output logic [31:0] MEM_DATA,
    input  logic [31:0] MEM_Q
);

    localparam logic [1:0] c_SZ_BYTE = 2'b00;
    localparam logic [1:0] c_SZ_HALF = 2'b01;
    localparam logic [1:0] c_SZ_WORD = 2'b10;
    localparam logic [1:0] c_SZ_BAD  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                rw_q, rw_d;
    logic [1:0]          size_q, size_d;
    logic                sgn_q, sgn_d;
    logic [1:0]          off_q, off_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                err_q, err_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_data_q, mem_data_d;

    // Request checks, evaluated on the raw inputs while in IDLE.
    logic w_range_err;
    logic w_size_err;
    logic w_mis_err;
    logic w_req_err;

    assign w_range_err = |ADDR[31:ADDR_W+2];
    assign w_size_err  = (SIZE == c_SZ_BAD);
`ifdef LSU_MISALIGN_TRAP_EN
    assign w_mis_err   = ((SIZE == c_SZ_HALF) && ADDR[0]) ||
                         ((SIZE == c_SZ_WORD) && (|ADDR[1:0]));
`else
    assign w_mis_err   = 1'b0;
`endif
    assign w_req_err   = w_range_err | w_size_err | w_mis_err;

    // Lane extraction and merge. A misaligned half always uses offset bit 1
    // only, so the truncating behaviour falls out of the lane select.
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_merge;

    assign w_byte = MEM_Q[{off_q, 3'b000} +: 8];
    assign w_half = MEM_Q[{off_q[1], 4'b0000} +: 16];

    always_comb begin
        w_load  = MEM_Q;
        w_merge = MEM_Q;
        case (size_q)
            c_SZ_BYTE: begin
                w_load = {{24{sgn_q & w_byte[7]}}, w_byte};
                w_merge[{off_q, 3'b000} +: 8] = wdata_q[7:0];
            end
            c_SZ_HALF: begin
                w_load = {{16{sgn_q & w_half[15]}}, w_half};
                w_merge[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            end
            default: begin
                w_load  = MEM_Q;
                w_merge = wdata_q;
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        rw_d       = rw_q;
        size_d     = size_q;
        sgn_d      = sgn_q;
        off_d      = off_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        case (state_q)
            IDLE: begin
                if (REQ) begin
                    rw_d    = RW;
                    size_d  = SIZE;
                    sgn_d   = SIGNED;
                    off_d   = ADDR[1:0];
                    idx_d   = ADDR[ADDR_W+1:2];
                    wdata_d = WDATA;
                    err_d   = w_req_err;
                    if (w_req_err) begin
                        // Rejected: memory address/data outputs untouched.
                        state_d = FIN;
                    end else if (RW && (SIZE == c_SZ_WORD)) begin
                        state_d    = WR;
                        mem_addr_d = ADDR[ADDR_W+1:2];
                        mem_data_d = WDATA;
                    end else begin
                        state_d    = RD;
                        mem_addr_d = ADDR[ADDR_W+1:2];
                    end
                end
            end
            RD: begin
                if (rw_q) begin
                    mem_data_d = w_merge;
                    state_d    = WR;
                end else begin
                    rdata_d = w_load;
                    state_d = FIN;
                end
            end
            WR:      state_d = FIN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            rw_q       <= 1'b0;
            size_q     <= 2'b00;
            sgn_q      <= 1'b0;
            off_q      <= 2'b00;
            idx_q      <= '0;
            wdata_q    <= 32'd0;
            err_q      <= 1'b0;
            rdata_q    <= 32'd0;
            mem_addr_q <= '0;
            mem_data_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            rw_q       <= rw_d;
            size_q     <= size_d;
            sgn_q      <= sgn_d;
            off_q      <= off_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
        end
    end

    // Pure state decodes: an asynchronous reset forces IDLE, which drops
    // MEM_WE before the next edge so an aborted store never writes.
    assign READY       = (state_q == IDLE);
    assign DONE        = (state_q == FIN);
    assign ERR         = (state_q == FIN) && err_q;
    assign MEM_WE      = (state_q == WR);
    assign RDATA       = rdata_q;
    assign MEM_ADDRESS = {{(32-ADDR_W){1'b0}}, mem_addr_q};
    assign MEM_DATA    = mem_data_q;

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Processor-side initiator for the single-port word data memory (combinational read on `Q`, write on `posedge CLK` when `WE=1`, word-indexed `ADDRESS`). It accepts byte/halfword/word loads and stores from the execute stage, with byte addresses and a REQ/READY/DONE handshake. It converts each request into word-indexed memory cycles, using read-modify-write for sub-word stores. It returns sign/zero-extended load data, and flags misaligned or out-of-range accesses.

## Interface
- `ADDR_W`, 10: word-index width; memory depth is 2**ADDR_W words.
- `CLK`  in  1  clock; all state changes on rising edge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `REQ`  in  1  request valid; sampled only while `READY=1`.
- `RW`  in  1  0 = load, 1 = store.
- `SIZE`  in  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal.
- `SIGNED`  in  1  load extension: 1 = sign-extend, 0 = zero-extend.
- `ADDR`  in  32  byte address.
- `WDATA`  in  32  store data, right-aligned.
- `READY`  out  1  high only in IDLE.
- `DONE`  out  1  one-cycle completion pulse.
- `ERR`  out  1  valid with `DONE`; request rejected, no memory write.
- `RDATA`  out  32  load result; holds until the next successful load.
- `MEM_WE`  out  1  to memory `WE`.
- `MEM_ADDRESS`  out  32  to memory `ADDRESS`: zero-extended word index `ADDR[ADDR_W+1:2]`.
- `MEM_DATA`  out  32  to memory `DATA`.
- `MEM_Q`  in  32  from memory `Q`.

## Operation
- States: IDLE, RD, WR, FIN.
- IDLE + `REQ`: register `RW`, `SIZE`, `SIGNED`, byte offset, word index and `WDATA`, then check for errors.
  - Error: next state FIN, `ERR=1`.
  - Load: next state RD.
  - Word store: next state WR.
  - Byte/half store: next state RD.
- Error conditions:
  - `SIZE=11`.
  - `ADDR[31:ADDR_W+2]` nonzero.
  - Misalignment (byte address not a multiple of the access size): see Configuration.
- RD: `MEM_ADDRESS` driven from the registered index.
  - Load: extract the lane from `MEM_MQ`, extend it, register it into `RDATA`, then go to FIN.
  - Sub-word store: capture `MEM_Q` into the merge register, then go to WR.
- Lanes are little-endian.
  - Byte k = `[8k+7:8k]`, where k = `ADDR[1:0]`.
  - Half h = `[16h+15:16h]`, where h = `ADDR[1]`.
- WR: `MEM_WE=1`.
  - Word store: `MEM_DATA` = `WDATA`.
  - Sub-word store: `MEM_DATA` = captured word with only the addressed lane(s) replaced by the low bits of `WDATA`.
  - Next state FIN.
- FIN: `DONE=1`; `ERR` is set if the request was rejected. Next state IDLE.
- Stores never modify `RDATA`. Errored loads leave `RDATA` unchanged.
- `REQ` outside IDLE is ignored; there is no queuing.

## Timing
- Request accepted at edge n. Completion, with `DONE` high during the listed cycle:
  - Load: RD in cycle n+1; `RDATA` valid and `DONE` in cycle n+2.
  - Word store: WR in cycle n+1 (memory written at edge n+2); `DONE` in n+2.
  - Sub-word store: RD in n+1, WR in n+2 (written at edge n+3); `DONE` in n+3.
  - Error: `DONE`+`ERR` in n+1; `MEM_WE` never asserts.
- `READY` returns high the cycle after FIN, so the earliest next acceptance is the edge ending that cycle.
- `MEM_WE` is a decode of the state register: glitch-free and high exactly one cycle per store.
- `MEM_ADDRESS` and `MEM_DATA` hold their last values outside RD/WR.
- Reset values: state IDLE, `READY=1`, `DONE=0`, `ERR=0`, `RDATA=0`, `MEM_WE=0`, `MEM_ADDRESS=0`, `MEM_DATA=0`.
- Reset mid-operation aborts the operation immediately:
  - `MEM_WE` drops asynchronously, so no partial write occurs at the following edge.
  - No `DONE` is issued for the aborted request.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A misaligned half/word access completes with `ERR=1`.
  - No memory access.
- Undefined:
  - Misalignment is not checked; offset bits are truncated (half uses `ADDR[1]`, word ignores `ADDR[1:0]`).
  - `ERR` only reports `SIZE=11` or out-of-range.

## Test plan
- Word 3 = 0x8899AABB; signed byte load, `ADDR`=0x0D -> `RDATA`=0xFFFFFFAA, `DONE` at n+2, `ERR`=0; unsigned -> 0x000000AA.
- Byte store `WDATA`=0x00000055 to `ADDR`=0x0E, word 3 = 0x8899AABB -> `MEM_WE` high only in n+2, word 3 = 0x8855AABB, `DONE` at n+3.
- Word store 0xDEADBEEF to `ADDR`=0x10 -> `MEM_WE` in n+1, word 4 = 0xDEADBEEF, `DONE` n+2; word load of 0x10 returns 0xDEADBEEF.
- Half store 0x1234 to `ADDR`=0x0F:
  - With `LSU_MISALIGN_TRAP_EN`: `DONE`+`ERR` at n+1, memory unchanged.
  - Without: word 3 = 0x1234AABB.
- `ADDR`=0x00001000 with `ADDR_W`=10, and separately `SIZE`=11 -> `ERR`=1 at n+1, `MEM_WE` stays 0, `RDATA` unchanged.
- Assert `RST_N`=0 during WR of a sub-word store -> `MEM_WE`=0 immediately, target word unchanged, no `DONE`, `READY`=1 after release, next load succeeds.
